wb_mgt_arbiter: RTL and testbench

//  Two-master Wishbone arbiter in front of the shared internal bus inside top. Master 0 is the

---
 rtl/wb_mgt_arbiter_pkg.sv | 5 +
 rtl/wb_mgt_arbiter_if.sv | 14 +
 rtl/wb_arb_wdog.sv | 18 +
 rtl/wb_mgt_arbiter.sv | 60 ++++++
 tb/tb_wb_mgt_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/wb_mgt_arbiter_pkg.sv
// wb_mgt_arbiter_pkg: grant-state encodings and defaults for the Wishbone arbiter family
package wb_mgt_arbiter_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_G0 = 2'd1, ST_G1 = 2'd2} state_t;
    localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/wb_mgt_arbiter_if.sv
// wb_mgt_arbiter_if: one Wishbone classic link; master drives the request, slave answers
interface wb_mgt_arbiter_if #(parameter int AW = 24, parameter int DW = 32);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;
    modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack, err);
    modport slave (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/wb_arb_wdog.sv
// wb_arb_wdog: counts consecutive stalled strobe cycles and flags the one that hits the limit
module wb_arb_wdog
    import wb_mgt_arbiter_pkg::*;
#(parameter int TIMEOUT = DEF_TIMEOUT)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt;
    assign expire = en && cnt == W'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (rst || clr || !en || expire) cnt <= '0;
        else cnt <= cnt + 1'b1;
endmodule

// File: rtl/wb_mgt_arbiter.sv
// wb_mgt_arbiter: two-master round-robin Wishbone arbiter with a stall watchdog
// Grant is held for the whole bus cycle; the response mux follows the registered owner.
module wb_mgt_arbiter
    import wb_mgt_arbiter_pkg::*;
#(
    parameter int AW       = 24,
    parameter int DW       = 32,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter bit M0_FIRST = 1'b1
)
(
    input  logic mgt_wb_clk_i,
    input  logic mgt_wb_rst_i,
    wb_mgt_arbiter_if.slave  m0,
    wb_mgt_arbiter_if.slave  m1,
    wb_mgt_arbiter_if.master s,
    output logic busy_o,
    output logic owner_o
);
    state_t state, nxt, pick;
    logic last, g0, g1, stb_raw, stall, expire;
    assign g0 = state == ST_G0 && !mgt_wb_rst_i;
    assign g1 = state == ST_G1 && !mgt_wb_rst_i;
    assign stb_raw = (g0 && m0.cyc && m0.stb) || (g1 && m1.cyc && m1.stb);
    assign stall = stb_raw && !s.ack && !s.err;
    assign s.stb = stb_raw && !expire;
    assign busy_o = g0 || g1;
    assign owner_o = g1;
    // last holds the previously granted index; starting at 1 lets master 0 win the first tie
    always_ff @(posedge mgt_wb_clk_i)
        if (mgt_wb_rst_i) begin
            state <= ST_IDLE;
            last  <= M0_FIRST;
        end else begin
            state <= nxt;
            if (nxt != ST_IDLE) last <= nxt == ST_G1;
        end
    always_comb begin
        pick    = (m0.cyc && m1.cyc) ? (last ? ST_G0 : ST_G1) : m0.cyc ? ST_G0 : m1.cyc ? ST_G1 : ST_IDLE;
        nxt     = ((state == ST_G0 && m0.cyc) || (state == ST_G1 && m1.cyc)) ? state : pick;
        s.cyc   = g0 ? m0.cyc : g1 ? m1.cyc : 1'b0;
        s.we    = g0 ? m0.we : g1 ? m1.we : 1'b0;
        s.sel   = g0 ? m0.sel : g1 ? m1.sel : {(DW/8){1'b0}};
        s.adr   = g0 ? m0.adr : g1 ? m1.adr : {AW{1'b0}};
        s.dat_w = g0 ? m0.dat_w : g1 ? m1.dat_w : {DW{1'b0}};
        m0.ack   = g0 && s.ack;
        m0.err   = g0 && (s.err || expire);
        m0.dat_r = g0 ? s.dat_r : {DW{1'b0}};
        m1.ack   = g1 && s.ack;
        m1.err   = g1 && (s.err || expire);
        m1.dat_r = g1 ? s.dat_r : {DW{1'b0}};
    end
    wb_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (mgt_wb_clk_i),
        .rst    (mgt_wb_rst_i),
        .clr    (nxt != state),
        .en     (stall),
        .expire (expire)
    );
endmodule

// File: tb/tb_wb_mgt_arbiter.sv
// tb_wb_mgt_arbiter: directed vector table, watchdog sequences, then random traffic vs a reference model
module tb_wb_mgt_arbiter;
    localparam int TO = 8;
    localparam logic [23:0] ADR0 = 24'h000A00;
    localparam logic [23:0] ADR1 = 24'h000B11;
    localparam logic [31:0] RD = 32'hDEADBEEF;
    typedef struct {
        logic rst, c0, s0, c1, s1, ack, err;
        logic [7:0] f;
    } vec_t;
    logic clk = 1'b0;
    logic rst, busy, owner;
    int total = 0, bad = 0;
    vec_t tbl[$];
    wb_mgt_arbiter_if #(.AW(24), .DW(32)) m0_bus ();
    wb_mgt_arbiter_if #(.AW(24), .DW(32)) m1_bus ();
    wb_mgt_arbiter_if #(.AW(24), .DW(32)) s_bus ();
    wb_mgt_arbiter #(.AW(24), .DW(32), .TIMEOUT(TO), .M0_FIRST(1'b1)) dut (
        .mgt_wb_clk_i (clk),
        .mgt_wb_rst_i (rst),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .s            (s_bus),
        .busy_o       (busy),
        .owner_o      (owner)
    );
    always #5 clk = ~clk;
    task automatic add(input logic r, c0, s0, c1, s1, a, e, input logic [7:0] f);
        vec_t v;
        v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = a; v.err = e; v.f = f;
        tbl.push_back(v);
    endtask
    task automatic apply(input logic r, c0, s0, c1, s1, a, e);
        rst = r;
        m0_bus.cyc = c0; m0_bus.stb = s0;
        m1_bus.cyc = c1; m1_bus.stb = s1;
        s_bus.ack = a; s_bus.err = e;
    endtask
    // flags: {s_cyc, s_stb, m0_ack, m0_err, m1_ack, m1_err, busy, owner}
    task automatic check(input string nm, input logic [7:0] ef, input logic [31:0] e0, e1, input logic [23:0] ea);
        logic [7:0] af;
        af = {s_bus.cyc, s_bus.stb, m0_bus.ack, m0_bus.err, m1_bus.ack, m1_bus.err, busy, owner & busy};
        total++;
        if (af !== ef) begin
            bad++;
            $display("FAIL %s flags got=%b want=%b", nm, af, ef);
        end
        total++;
        if ({m0_bus.dat_r, m1_bus.dat_r, s_bus.adr} !== {e0, e1, ea}) begin
            bad++;
            $display("FAIL %s data got=%h/%h/%h want=%h/%h/%h", nm, m0_bus.dat_r, m1_bus.dat_r, s_bus.adr, e0, e1, ea);
        end
    endtask
    task automatic step(input string nm, input logic [7:0] f);
        @(negedge clk);
        check(nm, f, (f[1] && !f[0]) ? RD : 32'h0, (f[1] && f[0]) ? RD : 32'h0, f[1] ? (f[0] ? ADR1 : ADR0) : 24'h0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        int mo, mw, nw, own;
        logic mp, rs, tmo;
        logic [7:0] ef;
        logic [31:0] d;
        logic [23:0] a0, a1;
        apply(1, 0, 0, 0, 0, 0, 0);
        m0_bus.we = 1'b0; m0_bus.sel = 4'hF; m0_bus.adr = ADR0; m0_bus.dat_w = 32'h11111111;
        m1_bus.we = 1'b1; m1_bus.sel = 4'h3; m1_bus.adr = ADR1; m1_bus.dat_w = 32'h22222222;
        s_bus.dat_r = RD;
        // single m0 read, ack two cycles after strobe
        add(1, 0, 0, 0, 0, 0, 0, 8'b00000000);
        add(0, 1, 1, 0, 0, 0, 0, 8'b00000000);
        add(0, 1, 1, 0, 0, 0, 0, 8'b11000010);
        add(0, 1, 1, 0, 0, 0, 0, 8'b11000010);
        add(0, 1, 1, 0, 0, 1, 0, 8'b11100010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        // simultaneous requests after reset, release without bubble, alternation
        add(1, 0, 0, 0, 0, 0, 0, 8'b00000000);
        add(0, 1, 1, 1, 1, 0, 0, 8'b00000000);
        add(0, 1, 1, 1, 1, 0, 0, 8'b11000010);
        add(0, 1, 1, 1, 1, 1, 0, 8'b11100010);
        add(0, 0, 0, 1, 1, 0, 0, 8'b00000010);
        add(0, 0, 0, 1, 1, 1, 0, 8'b11001011);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000011);
        add(0, 1, 1, 1, 1, 0, 0, 8'b00000000);
        add(0, 1, 1, 1, 1, 0, 0, 8'b11000010);
        add(0, 0, 0, 1, 1, 0, 0, 8'b00000010);
        // m1 burst of four beats holds the bus against m0
        add(0, 1, 1, 1, 1, 0, 0, 8'b11000011);
        add(0, 1, 1, 1, 1, 1, 0, 8'b11001011);
        add(0, 1, 1, 1, 1, 1, 0, 8'b11001011);
        add(0, 1, 1, 1, 1, 1, 0, 8'b11001011);
        add(0, 1, 1, 1, 1, 1, 0, 8'b11001011);
        add(0, 1, 1, 0, 0, 0, 0, 8'b00000011);
        add(0, 1, 1, 0, 0, 0, 0, 8'b11000010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        // reset during an m1 beat, then m0 wins the tie again
        add(0, 0, 0, 1, 1, 0, 0, 8'b00000000);
        add(0, 0, 0, 1, 1, 0, 0, 8'b11000011);
        add(1, 0, 0, 1, 1, 1, 0, 8'b00000000);
        add(0, 1, 1, 1, 1, 0, 0, 8'b00000000);
        add(0, 1, 1, 1, 1, 0, 0, 8'b11000010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000010);
        // m0 abandons its beat; the straggling ack must not reach m1
        add(0, 1, 1, 0, 0, 0, 0, 8'b00000000);
        add(0, 1, 1, 1, 1, 0, 0, 8'b11000010);
        add(0, 0, 0, 1, 1, 1, 0, 8'b00100010);
        add(0, 0, 0, 1, 1, 0, 0, 8'b11000011);
        add(0, 0, 0, 1, 1, 1, 0, 8'b11001011);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000011);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        // slave error passes straight through
        add(0, 1, 1, 0, 0, 0, 0, 8'b00000000);
        add(0, 1, 1, 0, 0, 0, 1, 8'b11010010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000010);
        add(0, 0, 0, 0, 0, 0, 0, 8'b00000000);
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err);
            step($sformatf("row%0d", i), tbl[i].f);
        end
        // watchdog expiry on the eighth stalled strobe cycle
        apply(0, 1, 1, 0, 0, 0, 0);
        step("to_req", 8'b00000000);
        for (int k = 1; k < TO; k++) step($sformatf("to_stall%0d", k), 8'b11000010);
        step("to_expire", 8'b10010010);
        step("to_restart", 8'b11000010);
        apply(0, 0, 0, 0, 0, 0, 0);
        step("to_release", 8'b00000010);
        step("to_idle", 8'b00000000);
        // ack in the expiry cycle wins over err
        apply(0, 1, 1, 0, 0, 0, 0);
        step("ta_req", 8'b00000000);
        for (int k = 1; k < TO; k++) step($sformatf("ta_stall%0d", k), 8'b11000010);
        apply(0, 1, 1, 0, 0, 1, 0);
        step("ta_ack", 8'b11100010);
        apply(0, 0, 0, 0, 0, 0, 0);
        step("ta_release", 8'b00000010);
        step("ta_idle", 8'b00000000);
        // random traffic against a transaction-level owner/stall model
        mo = 0; mp = 1'b1; mw = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, c0, s0, c1, s1, ak, er;
            r  = (i == 0) || ($urandom_range(0, 199) == 0);
            c0 = m0_bus.cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            c1 = m1_bus.cyc ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            s0 = c0 && ($urandom_range(0, 3) != 0);
            s1 = c1 && ($urandom_range(0, 3) != 0);
            ak = $urandom_range(0, 4) == 0;
            er = $urandom_range(0, 23) == 0;
            d = $urandom; a0 = 24'($urandom); a1 = 24'($urandom);
            apply(r, c0, s0, c1, s1, ak, er);
            s_bus.dat_r = d; m0_bus.adr = a0; m1_bus.adr = a1;
            @(negedge clk);
            own = r ? 0 : mo;
            rs  = own == 1 ? (c0 && s0) : own == 2 ? (c1 && s1) : 1'b0;
            tmo = rs && !ak && !er && mw == TO - 1;
            ef  = {own == 1 ? c0 : own == 2 ? c1 : 1'b0, rs && !tmo, own == 1 && ak, own == 1 && (er || tmo),
                   own == 2 && ak, own == 2 && (er || tmo), own != 0, own == 2};
            check($sformatf("rnd%0d", i), ef, own == 1 ? d : 32'h0, own == 2 ? d : 32'h0,
                  own == 1 ? a0 : own == 2 ? a1 : 24'h0);
            @(posedge clk);
            if (r) begin
                mo = 0; mp = 1'b1; mw = 0;
            end else begin
                nw = (mo == 1 && c0) ? 1 : (mo == 2 && c1) ? 2 : (c0 && c1) ? (mp ? 1 : 2) : c0 ? 1 : c1 ? 2 : 0;
                mw = (nw == mo && rs && !ak && !er && !tmo) ? mw + 1 : 0;
                if (nw != 0) mp = nw == 2;
                mo = nw;
            end
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
